generic_rw_arbiter: RTL and testbench

//  Round-robin arbiter that multiplexes NUM_PORTS sized read/write requesters onto one

---
 rtl/generic_rw_arbiter.sv | 157 +++++++++++++++
 tb/tb_generic_rw_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/generic_rw_arbiter.sv
// generic_rw_arbiter: round-robin arbiter that places NUM_PORTS read/write
// requesters onto a single downstream memory bus, one transaction at a time.
// The completion pulse (and any read data) is routed back to the granted port.
// Optional feature macro: ARB_TIMEOUT_EN. When it is defined, a BUSY phase that
// lasts TIMEOUT cycles without mem_response is forced to an error completion.
module generic_rw_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 65536,
  parameter int TIMEOUT   = 16,
  localparam int ADDR_W   = $clog2(DEPTH),
  localparam int IDX_W    = $clog2(WIDTH),
  localparam int PID_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_address,
  input  logic [NUM_PORTS-1:0]        req_read,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS*WIDTH-1:0]  req_wdata,
  input  logic [NUM_PORTS*IDX_W-1:0]  req_index,
  output logic [WIDTH-1:0]            req_rdata,
  output logic [NUM_PORTS-1:0]        req_response,
  output logic [NUM_PORTS-1:0]        req_error,
  output logic [ADDR_W-1:0]           mem_address,
  output logic                        mem_enable,
  output logic                        mem_valid,
  output logic [WIDTH-1:0]            mem_wdata,
  output logic [IDX_W-1:0]            mem_index,
  input  logic [WIDTH-1:0]            mem_rdata,
  input  logic                        mem_response
);

  if (NUM_PORTS < 1 || TIMEOUT < 1) begin : g_param_check
    $error("generic_rw_arbiter: NUM_PORTS and TIMEOUT must both be >= 1");
  end

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t               state, state_n;
  logic [PID_W-1:0]     rr;
  logic [PID_W-1:0]     grant;
  logic [PID_W-1:0]     sel;
  logic [PID_W-1:0]     scan;
  logic                 found;
  logic                 op_wr;
  logic [NUM_PORTS-1:0] cand;
  logic                 done;
  logic                 tmo;

  assign cand = req_read | req_write;
  assign done = (state == BUSY) && mem_response;

  // Round-robin search: scan from the highest offset down so the port closest to rr wins last.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    scan  = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      scan = PID_W'((int'(rr) + i) % NUM_PORTS);
      if (cand[scan]) begin
        found = 1'b1;
        sel   = scan;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;

  // BUSY cycle counter; zero on BUSY entry, so cnt==TIMEOUT-1 marks the last allowed cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)               cnt <= '0;
    else if (state != BUSY)     cnt <= '0;
    else if (!mem_response)     cnt <= cnt + 1'b1;
  end

  // A response arriving in the expiry cycle takes priority over the timeout.
  assign tmo = (state == BUSY) && !mem_response && (cnt == CNT_W'(TIMEOUT - 1));

  // Error flag accompanies the response pulse only when the transaction timed out.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                       req_error <= '0;
    else if (state == BUSY && tmo)      req_error <= NUM_PORTS'(1) << grant;
    else if (state == RESP)             req_error <= '0;
  end
`else
  assign tmo       = 1'b0;
  assign req_error = '0;
`endif

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // FSM next-state: IDLE -> BUSY on a grant, BUSY -> RESP on completion/timeout, RESP lasts one cycle.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (found) state_n = BUSY;
      BUSY:    if (done || tmo) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Registered bus outputs, grant bookkeeping and the round-robin pointer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr           <= '0;
      grant        <= '0;
      op_wr        <= 1'b0;
      mem_address  <= '0;
      mem_enable   <= 1'b0;
      mem_valid    <= 1'b0;
      mem_wdata    <= '0;
      mem_index    <= '0;
      req_rdata    <= '0;
      req_response <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant       <= sel;
            op_wr       <= req_write[sel];
            mem_address <= req_address[int'(sel)*ADDR_W +: ADDR_W];
            mem_index   <= req_index[int'(sel)*IDX_W +: IDX_W];
            mem_wdata   <= req_write[sel] ? req_wdata[int'(sel)*WIDTH +: WIDTH] : '0;
            mem_enable  <= ~req_write[sel];
            mem_valid   <= req_write[sel];
          end
        end
        BUSY: begin
          if (done || tmo) begin
            mem_address  <= '0;
            mem_enable   <= 1'b0;
            mem_valid    <= 1'b0;
            mem_wdata    <= '0;
            mem_index    <= '0;
            req_rdata    <= (done && !op_wr) ? mem_rdata : '0;
            req_response <= NUM_PORTS'(1) << grant;
          end
        end
        RESP: begin
          req_response <= '0;
          req_rdata    <= '0;
          rr           <= (int'(grant) == NUM_PORTS - 1) ? '0 : grant + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_generic_rw_arbiter.sv
// tb_generic_rw_arbiter: directed bench for generic_rw_arbiter with a
// transaction-level reference model compared against the DUT every cycle,
// plus literal expectations at hand-computed cycles.
module tb_generic_rw_arbiter;
  localparam int NP  = 2;
  localparam int W   = 32;
  localparam int DEP = 65536;
  localparam int TMO = 4;
  localparam int AW  = 16;
  localparam int IW  = 5;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [NP*AW-1:0] req_address;
  logic [NP-1:0]   req_read;
  logic [NP-1:0]   req_write;
  logic [NP*W-1:0] req_wdata;
  logic [NP*IW-1:0] req_index;
  logic [W-1:0]    req_rdata;
  logic [NP-1:0]   req_response;
  logic [NP-1:0]   req_error;
  logic [AW-1:0]   mem_address;
  logic            mem_enable;
  logic            mem_valid;
  logic [W-1:0]    mem_wdata;
  logic [IW-1:0]   mem_index;
  logic [W-1:0]    mem_rdata;
  logic            mem_response;

  generic_rw_arbiter #(.NUM_PORTS(NP), .WIDTH(W), .DEPTH(DEP), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_address(req_address), .req_read(req_read), .req_write(req_write),
    .req_wdata(req_wdata), .req_index(req_index), .req_rdata(req_rdata),
    .req_response(req_response), .req_error(req_error),
    .mem_address(mem_address), .mem_enable(mem_enable), .mem_valid(mem_valid),
    .mem_wdata(mem_wdata), .mem_index(mem_index), .mem_rdata(mem_rdata),
    .mem_response(mem_response)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  // owner: port currently holding the bus (-1 none); in_resp: completion pulse is showing.
  int            owner   = -1;
  bit            owner_wr = 1'b0;
  bit            in_resp = 1'b0;
  int            m_rr    = 0;
  int            busy_n  = 0;
  int            pick;
  logic [AW-1:0] e_addr  = '0;
  logic          e_en    = 1'b0;
  logic          e_val   = 1'b0;
  logic [W-1:0]  e_wdata = '0;
  logic [IW-1:0] e_idx   = '0;
  logic [W-1:0]  e_rdata = '0;
  logic [NP-1:0] e_resp  = '0;
  logic [NP-1:0] e_err   = '0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner = -1; in_resp = 1'b0; m_rr = 0; busy_n = 0;
      e_addr = '0; e_en = 1'b0; e_val = 1'b0; e_wdata = '0; e_idx = '0;
      e_rdata = '0; e_resp = '0; e_err = '0;
    end else if (in_resp) begin
      m_rr = (owner + 1) % NP;
      owner = -1; in_resp = 1'b0;
      e_resp = '0; e_err = '0; e_rdata = '0;
    end else if (owner >= 0) begin
      busy_n++;
      if (mem_response) begin
        e_rdata = owner_wr ? '0 : mem_rdata;
        e_addr = '0; e_en = 1'b0; e_val = 1'b0; e_wdata = '0; e_idx = '0;
        e_resp = '0; e_resp[owner] = 1'b1;
        in_resp = 1'b1;
      end
`ifdef ARB_TIMEOUT_EN
      else if (busy_n == TMO) begin
        e_rdata = '0;
        e_addr = '0; e_en = 1'b0; e_val = 1'b0; e_wdata = '0; e_idx = '0;
        e_resp = '0; e_resp[owner] = 1'b1;
        e_err  = '0; e_err[owner]  = 1'b1;
        in_resp = 1'b1;
      end
`endif
    end else begin
      pick = -1;
      for (int k = 0; k < NP; k++)
        if (pick < 0 && (req_read[(m_rr + k) % NP] || req_write[(m_rr + k) % NP]))
          pick = (m_rr + k) % NP;
      if (pick >= 0) begin
        owner    = pick;
        owner_wr = req_write[pick];
        busy_n   = 0;
        e_addr   = req_address[pick*AW +: AW];
        e_idx    = req_index[pick*IW +: IW];
        e_wdata  = owner_wr ? req_wdata[pick*W +: W] : '0;
        e_en     = !owner_wr;
        e_val    = owner_wr;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  bit            hold      = 1'b0;  // requesters keep requests up after completion
  bit            hold_resp = 1'b0;  // memory drives mem_response while no strobe is up
  int            mem_lat   = 1;     // strobe cycle (1-based) on which the memory answers
  int            strobe_cnt = 0;
  logic [W-1:0]  rd_val    = '0;
  logic [AW-1:0] log_ad[$];
  logic [W-1:0]  log_wd[$];
  logic          log_wr[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // One cycle: compare against the model at the falling edge, then react as requesters and memory.
  task automatic step();
    @(negedge clock);
    n_tests++;
    if ({mem_address, mem_enable, mem_valid, mem_wdata, mem_index, req_rdata, req_response, req_error}
        !== {e_addr, e_en, e_val, e_wdata, e_idx, e_rdata, e_resp, e_err}) begin
      n_fail++;
      $display("FAIL model_cmp t=%0t got addr=%0h en=%b val=%b wd=%0h idx=%0d rd=%0h rsp=%b err=%b expected addr=%0h en=%b val=%b wd=%0h idx=%0d rd=%0h rsp=%b err=%b",
               $time, mem_address, mem_enable, mem_valid, mem_wdata, mem_index, req_rdata, req_response, req_error,
               e_addr, e_en, e_val, e_wdata, e_idx, e_rdata, e_resp, e_err);
    end
    for (int p = 0; p < NP; p++)
      if (req_response[p] && !hold) begin
        if (req_write[p]) req_write[p] = 1'b0;
        else              req_read[p]  = 1'b0;
      end
    if (mem_enable || mem_valid) begin
      strobe_cnt++;
      if (strobe_cnt == 1) begin
        log_ad.push_back(mem_address);
        log_wd.push_back(mem_wdata);
        log_wr.push_back(mem_valid);
      end
      mem_response = (strobe_cnt >= mem_lat);
      mem_rdata    = rd_val;
    end else begin
      strobe_cnt   = 0;
      mem_response = hold_resp;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset_n = 1'b0;
    req_address = '0; req_read = '0; req_write = '0; req_wdata = '0; req_index = '0;
    mem_rdata = '0; mem_response = 1'b0;

    // reset state
    steps(2);
    chk("reset_strobes", {mem_enable, mem_valid}, 2'b00);
    chk("reset_resp", req_response, 2'b00);
    chk("reset_addr", mem_address, 16'h0);
    reset_n = 1'b1;
    steps(2);

    // port0 read, memory answers on the 3rd strobe cycle
    req_address[0*AW +: AW] = 16'h0010;
    req_index[0*IW +: IW]   = 5'd31;
    rd_val = 32'hDEADBEEF; mem_lat = 3;
    req_read[0] = 1'b1;
    step();
    chk("rd_enable", mem_enable, 1'b1);
    chk("rd_addr", mem_address, 16'h0010);
    chk("rd_index", mem_index, 5'd31);
    step(); step();
    chk("rd_no_early_resp", req_response, 2'b00);
    step();
    chk("rd_resp", req_response, 2'b01);
    chk("rd_rdata", req_rdata, 32'hDEADBEEF);
    chk("rd_strobe_clear", mem_enable, 1'b0);
    step();
    chk("rd_pulse_one_cycle", req_response, 2'b00);
    steps(2);

    // port1 read stalled in BUSY, then async reset
    req_address[0*AW +: AW] = 16'h0100;
    req_address[1*AW +: AW] = 16'h0200;
    mem_lat = 1000;
    req_read[1] = 1'b1;
    steps(2);
    chk("busy_before_reset", mem_enable, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_strobe", mem_enable, 1'b0);
    chk("async_reset_addr", mem_address, 16'h0);
    req_read[1] = 1'b0;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_resp_after_reset", req_response, 2'b00);
    end
    // pointer back at 0: port0 wins over port1
    mem_lat = 1;
    req_read = 2'b11;
    step();
    chk("rr_reset_grant", mem_address, 16'h0100);
    steps(8);

    // both ports writing continuously -> alternating grants
    log_ad.delete(); log_wd.delete(); log_wr.delete();
    req_wdata[0*W +: W] = 32'hA;
    req_wdata[1*W +: W] = 32'hB;
    hold = 1'b1;
    req_write = 2'b11;
    steps(13);
    req_write = 2'b00;
    hold = 1'b0;
    steps(6);
    chk("rot_count", log_wd.size() >= 4, 1'b1);
    if (log_wd.size() >= 4) begin
      chk("rot_wd0", log_wd[0], 32'hA);
      chk("rot_wd1", log_wd[1], 32'hB);
      chk("rot_wd2", log_wd[2], 32'hA);
      chk("rot_wd3", log_wd[3], 32'hB);
      chk("rot_ad1", log_ad[1], 16'h0200);
    end

    // port1 read and write together: write first, read afterwards
    log_ad.delete(); log_wd.delete(); log_wr.delete();
    req_wdata[1*W +: W] = 32'hC;
    rd_val = 32'h12345678; mem_lat = 2;
    req_read[1] = 1'b1; req_write[1] = 1'b1;
    steps(14);
    chk("rw_count", log_wr.size() >= 2, 1'b1);
    if (log_wr.size() >= 2) begin
      chk("rw_first_is_write", log_wr[0], 1'b1);
      chk("rw_first_wdata", log_wd[0], 32'hC);
      chk("rw_second_is_read", log_wr[1], 1'b0);
      chk("rw_read_wdata_zero", log_wd[1], 32'h0);
    end
    chk("rw_all_dropped", {req_read, req_write}, 4'b0000);

    // mem_response held high while idle with nobody requesting
    hold_resp = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_resp_ignored", {req_response, mem_enable, mem_valid}, 4'b0000);
    end
    hold_resp = 1'b0;
    steps(2);

`ifdef ARB_TIMEOUT_EN
    // no memory answer -> error completion after 4 BUSY cycles
    mem_lat = 1000;
    req_read[0] = 1'b1;
    steps(4);
    chk("tmo_not_yet", req_response, 2'b00);
    step();
    chk("tmo_resp", req_response, 2'b01);
    chk("tmo_err", req_error, 2'b01);
    chk("tmo_rdata", req_rdata, 32'h0);
    steps(3);
    // answer on the 4th BUSY cycle beats the timeout
    mem_lat = 4; rd_val = 32'h55AA55AA;
    req_read[0] = 1'b1;
    steps(5);
    chk("tmo_race_resp", req_response, 2'b01);
    chk("tmo_race_err", req_error, 2'b00);
    chk("tmo_race_rdata", req_rdata, 32'h55AA55AA);
    steps(3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
